spi_tx: RTL
===========

SPI_TX -- requirements
Module: spi_tx

Interface
REQ-001 Parameter: DW, 8, data word width in bits.
REQ-002 Parameter: IDLE_LVL, 1'b0, level driven on bit when no data is being shifted.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_b  input  1  reset; asynchronous, active-low.
REQ-005 data  input  DW  parallel word to transmit; sampled only on an accepted load.
REQ-006 load  input  1  request to transmit data; accepted on rising edge when ready=1.
REQ-007 abort  input  1  active-high; discards in-flight and buffered words.
REQ-008 bit  output  1  serial data, MSB first, registered, one bit per clock.
REQ-009 active  output  1  registered; high exactly while bit carries a data bit.
REQ-010 done  output  1  registered, one-cycle pulse coincident with the LSB of each word on bit.
REQ-011 ready  output  1  high when the one-word holding buffer is empty; load is accepted only then.

Function
REQ-012 Storage: DW-bit shift register, DW-bit holding register with full flag, bit counter of ceil(log2(DW)) bits, two-state FSM IDLE/SHIFT.
REQ-013 IDLE: bit=IDLE_LVL, active=0, done=0, ready=1.
REQ-014 Accepted load in IDLE: data loads the shift register directly; after that same edge, FSM=SHIFT, bit=data[DW-1], active=1, counter=0.
REQ-015 SHIFT: each edge shifts left by one; the bit output steps through data[DW-1] down to data[0]; each bit is held exactly one clock.
REQ-016 Latency: the MSB appears on bit the cycle after the accepting edge; the LSB appears DW cycles after the accepting edge.
REQ-017 Accepted load in SHIFT: data goes to the holding register; ready=0 from the next cycle.
REQ-018 Accepted load in SHIFT on the LSB cycle with the holding buffer empty: data loads the shift register directly, so the stream stays gapless.
REQ-019 LSB cycle with holding buffer full: the holding word moves to the shift register on the next edge; its MSB follows the previous LSB with no gap; active stays 1; hold is cleared; ready=1 next cycle.
REQ-020 LSB cycle with nothing buffered and no load: the next edge returns the FSM to IDLE; bit=IDLE_LVL; active=0.
REQ-021 done=1 only during the cycle bit carries the LSB of a word; a continuous stream gives one pulse every DW cycles.
REQ-022 load while ready=0: ignored; the holding register is unchanged; no error is flagged.
REQ-023 abort=1 at an edge: FSM=IDLE, the holding buffer is emptied, and the counter is cleared. From the next cycle bit=IDLE_LVL, active=0, ready=1. No done pulse is produced for the discarded word.
REQ-024 abort and load at the same edge: abort wins; data is discarded; no transmission starts.
REQ-025 abort while IDLE: no effect.
REQ-026 data changes after the accepting edge do not affect the word being transmitted.

Reset
REQ-027 rst_b=0 takes effect immediately, without waiting for a clock edge.
REQ-028 Reset values: FSM=IDLE, bit=IDLE_LVL, active=0, done=0, ready=1, shift register=0, holding register=0, hold flag=0, counter=0.
REQ-029 Reset mid-word: the partial word is lost; after release, the first accepted load starts a fresh word per REQ-014.

Verification
REQ-030 Single word: DW=8; data=8'hCA with one-cycle load from IDLE -> bit=1,1,0,0,1,0,1,0 on cycles 1-8; active=1 on cycles 1-8; done=1 on cycle 8 only; IDLE_LVL on cycle 9.
REQ-031 Back-to-back: 8'hCA accepted, then 8'h3F accepted on cycle 2 -> ready=0 until the CA LSB; 16 contiguous bits 11001010 00111111; done on cycles 8 and 16.
REQ-032 Abort: abort pulsed after 3 bits of 8'hCA with 8'h3F buffered -> bit=IDLE_LVL next cycle; ready=1; no done; next load of 8'hA7 gives 10100111.
REQ-033 Collisions: load with abort at the same edge -> no transmission. A third load while the buffer is full -> ignored; only the first two words appear.
REQ-034 Reset: rst_b low mid-word, asynchronous to clk -> outputs reach REQ-028 values before the next edge; after release, a load of 8'h3F gives 00111111.

Source files
------------

// File: rtl/spi_tx.sv
// MSB-first serial transmitter with a one-word holding buffer.
// Back-to-back words stream with no idle gap; abort drops everything.
module spi_tx #(
  parameter int   DW       = 8,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic [DW-1:0] data,
  input  logic          load,
  input  logic          abort,
  // serial data out; named tx_bit since bit is a reserved word
  output logic          tx_bit,
  output logic          active,
  output logic          done,
  output logic          ready
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] shreg, shreg_n;
  logic [DW-1:0] hold, hold_n;
  logic          full, full_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          bit_n, active_n, done_n;
  logic          accept, lsb;

  assign ready  = ~full;
  assign accept = load & ~full;
  assign lsb    = (cnt == LAST);

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    hold_n  = hold;
    full_n  = full;
    cnt_n   = cnt;
    if (abort) begin
      state_n = IDLE;
      full_n  = 1'b0;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            shreg_n = data;
            state_n = SHIFT;
            cnt_n   = '0;
          end
        end
        SHIFT: begin
          if (!lsb) begin
            shreg_n = shreg << 1;
            cnt_n   = cnt + CW'(1);
            if (accept) begin
              hold_n = data;
              full_n = 1'b1;
            end
          end else if (full) begin
            shreg_n = hold;
            hold_n  = '0;
            full_n  = 1'b0;
            cnt_n   = '0;
          end else if (accept) begin
            shreg_n = data;
            cnt_n   = '0;
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // outputs follow the next-state shift register so they are pure flops
  always_comb begin
    bit_n    = IDLE_LVL;
    active_n = 1'b0;
    done_n   = 1'b0;
    if (state_n == SHIFT) begin
      bit_n    = shreg_n[DW-1];
      active_n = 1'b1;
      done_n   = (cnt_n == LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state  <= IDLE;
      shreg  <= '0;
      hold   <= '0;
      full   <= 1'b0;
      cnt    <= '0;
      tx_bit <= IDLE_LVL;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      shreg  <= shreg_n;
      hold   <= hold_n;
      full   <= full_n;
      cnt    <= cnt_n;
      tx_bit <= bit_n;
      active <= active_n;
      done   <= done_n;
    end
  end

endmodule
